// File: rtl/io_pkg.sv
// io_pkg: shared constants for the io_ctrl byte I/O responder.
package io_pkg;

  // Width of one transferred byte
  localparam int BYTE_W = 8;

  // Width of the sticky error vector and the bit position of each flag
  localparam int ERR_W        = 5;
  localparam int ERR_RX_OVF   = 0;
  localparam int ERR_RX_FERR  = 1;
  localparam int ERR_TX_STALL = 2;

endpackage : io_pkg

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO with 2**DEPTH_LOG2 entries.
// Pointers carry one extra MSB so that full and empty are distinguishable.
// The head byte, empty and full flags are all registered; the head is
// forced to zero whenever the FIFO is empty.
module byte_fifo
  import io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              full_next
);

  localparam int               PTR_W     = DEPTH_LOG2 + 1;
  localparam int               DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [BYTE_W-1:0] head_r;
  logic              empty_r;
  logic              full_r;

  logic              pop_ok_s;
  logic              push_ok_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  cnt_nxt_s;
  logic [BYTE_W-1:0] head_nxt_s;

  // Qualify push/pop, advance pointers and pick the byte that will be at the head next cycle
  always_comb begin
    pop_ok_s     = pop && !empty_r;
    push_ok_s    = push && (!full_r || pop_ok_s);
    wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_ok_s);
    rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_ok_s);
    cnt_nxt_s    = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_next    = (cnt_nxt_s == DEPTH_CNT);
    if (cnt_nxt_s == {PTR_W{1'b0}}) begin
      head_nxt_s = {BYTE_W{1'b0}};
    end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      // The new head is the byte being written this very cycle
      head_nxt_s = din;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[DEPTH_LOG2-1:0]];
    end
  end

  // Pointer, flag and head-byte registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      head_r   <= {BYTE_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      head_r   <= head_nxt_s;
      empty_r  <= (cnt_nxt_s == {PTR_W{1'b0}});
      full_r   <= full_next;
    end
  end

  // Storage array; written at the write pointer on an accepted push
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {BYTE_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= din;
    end
  end

  assign dout  = head_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule : byte_fifo

// File: rtl/io_ctrl.sv
// io_ctrl: peripheral-side responder for the CPU byte I/O handshake.
// RX FIFO buffers UART bytes towards the CPU; TX FIFO buffers CPU bytes
// towards the UART transmitter; io_err carries sticky error flags.
// Build option: define IO_LOOPBACK_EN to add the lb_en port, which routes
// the TX FIFO head straight into the RX FIFO and silences the UART paths.
module io_ctrl
  import io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [BYTE_W-1:0] io_in_data,
  input  logic              io_in_rdy,
  output logic              io_in_vld,
  input  logic [BYTE_W-1:0] io_out_data,
  output logic              io_out_rdy,
  input  logic              io_out_vld,
  output logic [ERR_W-1:0]  io_err,
  input  logic              err_clr,
  input  logic [BYTE_W-1:0] uart_rx_data,
  input  logic              uart_rx_vld,
  input  logic              uart_rx_ferr,
  output logic [BYTE_W-1:0] uart_tx_data,
  output logic              uart_tx_vld,
  input  logic              uart_tx_rdy
`ifdef IO_LOOPBACK_EN
  ,
  input  logic              lb_en
`endif
);

  localparam int               CNT_W     = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(1 << DEPTH_LOG2);

  logic [BYTE_W-1:0] rx_dout_s;
  logic              rx_empty_s;
  logic              rx_full_s;
  logic              rx_full_next_unused_s;
  logic [BYTE_W-1:0] tx_dout_s;
  logic              tx_empty_s;
  logic              tx_full_unused_s;
  logic              tx_full_next_s;

  logic              lb_active_s;
  logic              rx_push_s;
  logic              rx_pop_s;
  logic [BYTE_W-1:0] rx_din_s;
  logic              rx_ferr_s;
  logic              tx_push_s;
  logic              tx_pop_s;
  logic              tx_vld_s;
  logic              stalled_s;
  logic [CNT_W-1:0]  stall_cnt_nxt_s;
  logic [ERR_W-1:0]  err_set_s;

  logic              out_rdy_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [ERR_W-1:0]  err_r;

`ifdef IO_LOOPBACK_EN
  logic lb_en_r;

  // Register the loopback enable so a mode change lands on a cycle boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lb_en_r <= 1'b0;
    end else begin
      lb_en_r <= lb_en;
    end
  end

  assign lb_active_s = lb_en_r;
`else
  assign lb_active_s = 1'b0;
`endif

  // Route bytes between the UART, the CPU and the two FIFOs
  always_comb begin
    rx_pop_s  = !rx_empty_s && io_in_rdy;
    tx_push_s = io_out_vld && out_rdy_r;
    if (lb_active_s) begin
      // Loopback: TX head moves into RX only when RX has room, UART inputs ignored
      rx_push_s = !tx_empty_s && !rx_full_s;
      rx_din_s  = tx_dout_s;
      rx_ferr_s = 1'b0;
      tx_pop_s  = !tx_empty_s && !rx_full_s;
      tx_vld_s  = 1'b0;
    end else begin
      rx_push_s = uart_rx_vld;
      rx_din_s  = uart_rx_data;
      rx_ferr_s = uart_rx_ferr;
      tx_pop_s  = !tx_empty_s && uart_tx_rdy;
      tx_vld_s  = !tx_empty_s;
    end
  end

  // Count consecutive cycles the CPU is held off by a full TX FIFO
  always_comb begin
    stalled_s = io_out_vld && !out_rdy_r;
    if (tx_push_s) begin
      stall_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (stalled_s) begin
      if (stall_cnt_r != STALL_LIM) begin
        stall_cnt_nxt_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_nxt_s = stall_cnt_r;
      end
    end else begin
      stall_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Collect this cycle's error events
  always_comb begin
    err_set_s               = {ERR_W{1'b0}};
    err_set_s[ERR_RX_OVF]   = rx_push_s && rx_full_s && !rx_pop_s;
    err_set_s[ERR_RX_FERR]  = rx_ferr_s;
    err_set_s[ERR_TX_STALL] = stalled_s && (stall_cnt_r == (STALL_LIM - {{(CNT_W-1){1'b0}}, 1'b1}));
  end

  // TX ready, stall counter and sticky errors; a same-cycle set beats err_clr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_rdy_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      err_r       <= {ERR_W{1'b0}};
    end else begin
      out_rdy_r   <= !tx_full_next_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      err_r       <= (err_clr ? {ERR_W{1'b0}} : err_r) | err_set_s;
    end
  end

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rx_push_s),
    .pop       (rx_pop_s),
    .din       (rx_din_s),
    .dout      (rx_dout_s),
    .empty     (rx_empty_s),
    .full      (rx_full_s),
    .full_next (rx_full_next_unused_s)
  );

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (tx_push_s),
    .pop       (tx_pop_s),
    .din       (io_out_data),
    .dout      (tx_dout_s),
    .empty     (tx_empty_s),
    .full      (tx_full_unused_s),
    .full_next (tx_full_next_s)
  );

  assign io_in_data   = rx_dout_s;
  assign io_in_vld    = !rx_empty_s;
  assign io_out_rdy   = out_rdy_r;
  assign uart_tx_data = tx_dout_s;
  assign uart_tx_vld  = tx_vld_s;
  assign io_err       = err_r;

endmodule : io_ctrl

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed self-checking bench for io_ctrl (DEPTH_LOG2 = 4).
// Loopback vectors run only when IO_LOOPBACK_EN is defined.
module tb_io_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] io_in_data;
  logic       io_in_rdy;
  logic       io_in_vld;
  logic [7:0] io_out_data;
  logic       io_out_rdy;
  logic       io_out_vld;
  logic [4:0] io_err;
  logic       err_clr;
  logic [7:0] uart_rx_data;
  logic       uart_rx_vld;
  logic       uart_rx_ferr;
  logic [7:0] uart_tx_data;
  logic       uart_tx_vld;
  logic       uart_tx_rdy;
`ifdef IO_LOOPBACK_EN
  logic       lb_en;
`endif

  int checks = 0;
  int errors = 0;

  io_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .io_in_data   (io_in_data),
    .io_in_rdy    (io_in_rdy),
    .io_in_vld    (io_in_vld),
    .io_out_data  (io_out_data),
    .io_out_rdy   (io_out_rdy),
    .io_out_vld   (io_out_vld),
    .io_err       (io_err),
    .err_clr      (err_clr),
    .uart_rx_data (uart_rx_data),
    .uart_rx_vld  (uart_rx_vld),
    .uart_rx_ferr (uart_rx_ferr),
    .uart_tx_data (uart_tx_data),
    .uart_tx_vld  (uart_tx_vld),
    .uart_tx_rdy  (uart_tx_rdy)
`ifdef IO_LOOPBACK_EN
    ,
    .lb_en        (lb_en)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; io_in_rdy = 1'b0; io_out_data = 8'h00; io_out_vld = 1'b0;
    err_clr = 1'b0; uart_rx_data = 8'h00; uart_rx_vld = 1'b0;
    uart_rx_ferr = 1'b0; uart_tx_rdy = 1'b0;
`ifdef IO_LOOPBACK_EN
    lb_en = 1'b0;
`endif
    step(); step();
    check("rst_in_vld", 32'(io_in_vld), 32'd0);
    check("rst_in_data", 32'(io_in_data), 32'h00);
    check("rst_out_rdy", 32'(io_out_rdy), 32'd0);
    check("rst_tx_vld", 32'(uart_tx_vld), 32'd0);
    check("rst_err", 32'(io_err), 32'h00);
    rstn = 1'b1;
    step();
    check("post_rst_out_rdy", 32'(io_out_rdy), 32'd1);

    // RX basic
    uart_rx_vld = 1'b1; uart_rx_data = 8'h41;
    step();
    check("rx_vld_latency", 32'(io_in_vld), 32'd1);
    check("rx_head_41", 32'(io_in_data), 32'h41);
    uart_rx_data = 8'h42;
    step();
    uart_rx_vld = 1'b0;
    check("rx_head_still_41", 32'(io_in_data), 32'h41);
    io_in_rdy = 1'b1;
    step();
    io_in_rdy = 1'b0;
    check("rx_head_42", 32'(io_in_data), 32'h42);
    check("rx_vld_after_pop1", 32'(io_in_vld), 32'd1);
    io_in_rdy = 1'b1;
    step();
    io_in_rdy = 1'b0;
    check("rx_vld_after_pop2", 32'(io_in_vld), 32'd0);

    // RX overflow: 17 bytes into 16 entries
    for (int i = 0; i <= 16; i++) begin
      uart_rx_vld = 1'b1; uart_rx_data = 8'(i);
      step();
      if (i == 15) check("rx_no_ovf_at_16", 32'(io_err), 32'h00);
    end
    uart_rx_vld = 1'b0;
    check("rx_ovf_err", 32'(io_err), 32'h01);
    for (int i = 0; i < 16; i++) begin
      check("rx_drain_vld", 32'(io_in_vld), 32'd1);
      check("rx_drain_data", 32'(io_in_data), 32'(i));
      io_in_rdy = 1'b1;
      step();
    end
    io_in_rdy = 1'b0;
    check("rx_drain_empty", 32'(io_in_vld), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_ovf", 32'(io_err), 32'h00);

    // TX backpressure
    io_out_vld = 1'b1; io_out_data = 8'h55;
    step();
    io_out_data = 8'hAA;
    step();
    io_out_vld = 1'b0;
    check("tx_vld_bp", 32'(uart_tx_vld), 32'd1);
    check("tx_data_55", 32'(uart_tx_data), 32'h55);
    uart_tx_rdy = 1'b1;
    step();
    check("tx_data_aa", 32'(uart_tx_data), 32'hAA);
    check("tx_vld_aa", 32'(uart_tx_vld), 32'd1);
    step();
    uart_tx_rdy = 1'b0;
    check("tx_empty_after", 32'(uart_tx_vld), 32'd0);

    // TX full and stall
    for (int i = 0; i < 16; i++) begin
      io_out_vld = 1'b1; io_out_data = 8'(8'h10 + i);
      step();
    end
    io_out_data = 8'hEE;
    check("tx_full_rdy", 32'(io_out_rdy), 32'd0);
    check("tx_full_no_err", 32'(io_err), 32'h00);
    for (int i = 0; i < 15; i++) step();
    check("tx_stall_15", 32'(io_err), 32'h00);
    step();
    check("tx_stall_16", 32'(io_err), 32'h04);
    uart_tx_rdy = 1'b1;
    step();
    uart_tx_rdy = 1'b0;
    check("tx_rdy_after_pop", 32'(io_out_rdy), 32'd1);
    step();
    io_out_vld = 1'b0;
    check("tx_refull_rdy", 32'(io_out_rdy), 32'd0);
    uart_tx_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("tx_drain_data", 32'(uart_tx_data), (i == 16) ? 32'hEE : 32'(8'h10 + i));
      step();
    end
    uart_tx_rdy = 1'b0;
    check("tx_drain_empty", 32'(uart_tx_vld), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_stall", 32'(io_err), 32'h00);

    // Framing strobe coincident with err_clr: set wins
    uart_rx_ferr = 1'b1; err_clr = 1'b1;
    step();
    uart_rx_ferr = 1'b0; err_clr = 1'b0;
    check("ferr_vs_clr", 32'(io_err), 32'h02);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ferr_cleared", 32'(io_err), 32'h00);

    // Simultaneous push and pop on a full RX FIFO
    for (int i = 0; i < 16; i++) begin
      uart_rx_vld = 1'b1; uart_rx_data = 8'(8'h80 + i);
      step();
    end
    uart_rx_data = 8'h90; io_in_rdy = 1'b1;
    step();
    io_in_rdy = 1'b0;
    uart_rx_vld = 1'b0;
    check("full_pushpop_no_ovf", 32'(io_err), 32'h00);
    check("full_pushpop_head", 32'(io_in_data), 32'h81);
    uart_rx_vld = 1'b1; uart_rx_data = 8'h91;
    step();
    uart_rx_vld = 1'b0;
    check("full_still_16", 32'(io_err), 32'h01);
    for (int i = 1; i <= 16; i++) begin
      check("full_drain_data", 32'(io_in_data), (i == 16) ? 32'h90 : 32'(8'h80 + i));
      io_in_rdy = 1'b1;
      step();
    end
    io_in_rdy = 1'b0;
    check("full_drain_empty", 32'(io_in_vld), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Reset asserted mid-stream
    uart_rx_vld = 1'b1; uart_rx_data = 8'h11; io_out_vld = 1'b1; io_out_data = 8'h22;
    uart_rx_ferr = 1'b1;
    step();
    uart_rx_vld = 1'b0; io_out_vld = 1'b0; uart_rx_ferr = 1'b0;
    check("mid_rx_vld", 32'(io_in_vld), 32'd1);
    check("mid_tx_vld", 32'(uart_tx_vld), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_in_vld", 32'(io_in_vld), 32'd0);
    check("async_in_data", 32'(io_in_data), 32'h00);
    check("async_tx_vld", 32'(uart_tx_vld), 32'd0);
    check("async_tx_data", 32'(uart_tx_data), 32'h00);
    check("async_out_rdy", 32'(io_out_rdy), 32'd0);
    check("async_err", 32'(io_err), 32'h00);
    step();
    rstn = 1'b1;
    step();
    check("rel_in_vld", 32'(io_in_vld), 32'd0);
    check("rel_tx_vld", 32'(uart_tx_vld), 32'd0);
    check("rel_out_rdy", 32'(io_out_rdy), 32'd1);

`ifdef IO_LOOPBACK_EN
    // Loopback: TX byte reappears on the RX side, UART activity ignored
    lb_en = 1'b1;
    step();
    io_out_vld = 1'b1; io_out_data = 8'h33;
    uart_rx_vld = 1'b1; uart_rx_data = 8'h99; uart_rx_ferr = 1'b1;
    step();
    io_out_vld = 1'b0;
    check("lb_tx_vld_forced", 32'(uart_tx_vld), 32'd0);
    step();
    uart_rx_vld = 1'b0; uart_rx_ferr = 1'b0;
    check("lb_in_vld", 32'(io_in_vld), 32'd1);
    check("lb_in_data", 32'(io_in_data), 32'h33);
    check("lb_tx_vld_still0", 32'(uart_tx_vld), 32'd0);
    check("lb_no_err", 32'(io_err), 32'h00);
    io_in_rdy = 1'b1;
    step();
    io_in_rdy = 1'b0;
    check("lb_single_byte", 32'(io_in_vld), 32'd0);
    lb_en = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_io_ctrl
